arcade_input: RTL and testbench
===============================

Name: arcade_input

Overview:
- Player-input front end for the arcade core wrapper.
- Decodes PS/2 key events into held buttons and merges them with both HPS joysticks.
- Applies orientation remap, a 4-way direction arbiter and a coin/start sequencer.
- Drives the active-low in0/in1 ports of the game core directly; sits between hps_io and the game core.

Parameters:
- COIN_CYCLES, 2400000, CLK cycles the coin bit is asserted (100 ms at 24 MHz).
- GAP_CYCLES, 1200000, CLK cycles between coin release and start assertion.
- START_CYCLES, 2400000, CLK cycles the start bit is asserted.
- CNT_W, 22, width of the shared sequencer counter; must hold max(COIN_CYCLES, GAP_CYCLES, START_CYCLES).

Ports:
- CLK  in  1  system clock (24 MHz).
- RESET  in  1  asynchronous active-high reset.
- ps2_key  in  11  [10] toggle per event, [9] pressed, [8:0] extended scan code.
- joy0  in  16  joystick 0: [0] R, [1] L, [2] D, [3] U, [4] fire, [5] start1, [6] start2.
- joy1  in  16  joystick 1, same layout as joy0.
- rotate  in  1  1 = horizontal orientation remap.
- in0  out  8  active-low, ~{2'b00, coin, fire, down, right, left, up}.
- in1  out  8  active-low, ~{1'b0, start2, start1, 5'b0}.

Behaviour:
- Reset: all key latches 0, toggle shadow 0, direction mask 0, sequencer IDLE, counter 0, in0 = 8'hFF, in1 = 8'hFF.
- Key decode:
  - Register ps2_key once.
  - When registered [10] differs from its shadow, the matching latch takes [9].
  - Codes: X75 up, X72 down, X6B left, X74 right (extended bit ignored); 029 or 014 fire; 005 start1; 006 start2.
  - Unknown codes are ignored.
- Merge: joy = joy0 | joy1. Each function = key latch | joy bit.
- Orientation:
  - rotate = 0: {up, down, left, right} passes through unchanged.
  - rotate = 1: up <- left, down <- right, left <- down, right <- up.
- 4-way arbiter:
  - Two-stage registered copy of the 4 directions; rising edges are detected on that copy.
  - Any rising edge loads a one-hot mask. Same-cycle priority: up > down > left > right.
  - Output = stage1 & mask.
  - Releasing the masked direction yields no direction, even if another is held, until a new press.
- Sequencer FSM with states IDLE, COIN, GAP, START:
  - IDLE -> COIN on a rising edge of start1 or start2. The request (1 or 2) is latched; start1 wins if both rise in the same cycle.
  - COIN: coin = 1 for COIN_CYCLES, then go to GAP.
  - GAP: no outputs for GAP_CYCLES, then go to START.
  - START: the latched start bit = 1 for START_CYCLES, then back to IDLE.
  - Start edges outside IDLE are discarded.
  - The counter loads 0 on each state entry; the state exits when counter == N-1.
- Latency:
  - Key toggle to in0/in1 (non-sequenced bits): 3 CLK cycles.
  - Start edge to coin low on in0: 3 CLK cycles.
- Outputs: in0/in1 are registered and inverted.
- RESET mid-sequence: immediate return to IDLE and outputs go to FF. A start held through reset release does not trigger a new sequence, because edge detectors reset to 1 for start bits.

Optional Feature:
- Macro: ARCADE_INPUT_4WAY_EN.
- Defined: arbiter as above.
- Undefined: directions pass straight from the orientation stage through one register. Latency is unchanged (same pipeline depth), and opposite directions may be asserted simultaneously.

Decomposition:
- Package arcade_input_pkg holds:
  - seq_state_t enum {IDLE, COIN, GAP, START};
  - scan-code localparams;
  - in0/in1 bit-index localparams;
  - joystick bit-index localparams.
- Sub-module coin_start_seq (FSM + counter; parameters COIN_CYCLES, GAP_CYCLES, START_CYCLES, CNT_W) instantiated once.

Test Plan:
All runs use COIN_CYCLES = 4, GAP_CYCLES = 2, START_CYCLES = 3.
- Reset: RESET held, random inputs -> in0 = FF, in1 = FF. Release with joy0[5] = 1 held -> no coin pulse.
- Key decode: toggle ps2_key with {1, 0x075} -> in0[0] = 0 three cycles later. Toggle with {0, 0x175} -> in0[0] = 1. Same toggle value repeated -> no change.
- Sequencer: joy1[6] rises -> in0[5] = 0 for 4 cycles, then 2 cycles idle, then in1[6] = 0 for 3 cycles, then in1 = FF. A second start1 edge during GAP is ignored.
- Arbiter (4WAY_EN): hold left, then add up -> only in0[0] low. Release up while left is held -> in0[3:0] = F. Up and down rising in the same cycle -> up only.
- Rotation: rotate = 1, joy0[1] (L) held -> in0[0] (up) low. Joy0[3] (U) held -> in0[2] (right) low.
- Reset mid-COIN: assert RESET two cycles into COIN -> in0 = FF within the same cycle (async). After release, IDLE with no pending start.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: shared sequencer states, scan codes and bit indices for arcade_input
package arcade_input_pkg;
  typedef enum logic [1:0] {IDLE, COIN, GAP, START} seq_state_t;
  localparam logic [7:0] SC_UP = 8'h75, SC_DOWN = 8'h72, SC_LEFT = 8'h6B, SC_RIGHT = 8'h74;
  localparam logic [8:0] SC_FIRE_A = 9'h029, SC_FIRE_B = 9'h014, SC_START1 = 9'h005, SC_START2 = 9'h006;
  localparam int IN0_UP = 0, IN0_LEFT = 1, IN0_RIGHT = 2, IN0_DOWN = 3, IN0_FIRE = 4, IN0_COIN = 5;
  localparam int IN1_START1 = 5, IN1_START2 = 6;
  localparam int JOY_R = 0, JOY_L = 1, JOY_D = 2, JOY_U = 3, JOY_FIRE = 4, JOY_START1 = 5, JOY_START2 = 6;
endpackage

// File: rtl/arcade_input_coin_start_seq.sv
// coin_start_seq: start-edge triggered coin pulse, gap, then latched start pulse
module coin_start_seq
  import arcade_input_pkg::*;
#(
  parameter int COIN_CYCLES  = 2400000,
  parameter int GAP_CYCLES   = 1200000,
  parameter int START_CYCLES = 2400000,
  parameter int CNT_W        = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1,
  input  logic btn2,
  output logic coin,
  output logic start1,
  output logic start2
);
  localparam logic [CNT_W-1:0] C_END = CNT_W'(COIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] G_END = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] S_END = CNT_W'(START_CYCLES - 1);
  seq_state_t state_q, state_n;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0] s_q, s_q2, rise;
  logic req2_q;
  assign rise = s_q & ~s_q2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= 2'b11;
      s_q2    <= 2'b11;
      req2_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= (state_n != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
      s_q     <= {btn2, btn1};
      s_q2    <= s_q;
      req2_q  <= (state_q == IDLE && |rise) ? ~rise[0] : req2_q;
    end
  always_comb
    state_n = state_q == IDLE  ? (|rise ? COIN : IDLE) :
              state_q == COIN  ? (cnt_q == C_END ? GAP : COIN) :
              state_q == GAP   ? (cnt_q == G_END ? START : GAP) :
                                 (cnt_q == S_END ? IDLE : START);
  always_comb begin
    coin   = state_q == COIN;
    start1 = state_q == START && !req2_q;
    start2 = state_q == START && req2_q;
  end
endmodule

// File: rtl/arcade_input.sv
// arcade_input: PS/2 + joystick merge, rotation, 4-way arbiter (ARCADE_INPUT_4WAY_EN) and coin/start sequencer
module arcade_input
  import arcade_input_pkg::*;
#(
  parameter int COIN_CYCLES  = 2400000,
  parameter int GAP_CYCLES   = 1200000,
  parameter int START_CYCLES = 2400000,
  parameter int CNT_W        = 22
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy0,
  input  logic [15:0] joy1,
  input  logic        rotate,
  output logic [7:0]  in0,
  output logic [7:0]  in1
);
  logic [10:0] ps2_q;
  logic tog_q;
  logic [6:0] key_q, hit, btn;
  logic [3:0] dir, dir_q, dir_out;
  logic [7:4] hi_q;
  logic coin, start1, start2;
  logic unused;
  assign unused = ^{joy0[15:7], joy1[15:7]};
  always_comb begin
    hit = '0;
    hit[JOY_U] = ps2_q[7:0] == SC_UP;
    hit[JOY_D] = ps2_q[7:0] == SC_DOWN;
    hit[JOY_L] = ps2_q[7:0] == SC_LEFT;
    hit[JOY_R] = ps2_q[7:0] == SC_RIGHT;
    hit[JOY_FIRE] = ps2_q[8:0] == SC_FIRE_A || ps2_q[8:0] == SC_FIRE_B;
    hit[JOY_START1] = ps2_q[8:0] == SC_START1;
    hit[JOY_START2] = ps2_q[8:0] == SC_START2;
    btn = key_q | joy0[6:0] | joy1[6:0];
    dir = '0;
    dir[IN0_UP]    = rotate ? btn[JOY_L] : btn[JOY_U];
    dir[IN0_DOWN]  = rotate ? btn[JOY_R] : btn[JOY_D];
    dir[IN0_LEFT]  = rotate ? btn[JOY_D] : btn[JOY_L];
    dir[IN0_RIGHT] = rotate ? btn[JOY_U] : btn[JOY_R];
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      ps2_q <= '0;
      tog_q <= 1'b0;
      key_q <= '0;
      dir_q <= '0;
      hi_q  <= '1;
      in1   <= 8'hFF;
    end else begin
      ps2_q <= ps2_key;
      tog_q <= ps2_q[10];
      key_q <= (ps2_q[10] != tog_q) ? (key_q & ~hit) | ({7{ps2_q[9]}} & hit) : key_q;
      dir_q <= dir;
      hi_q  <= '1;
      hi_q[IN0_COIN] <= ~coin;
      hi_q[IN0_FIRE] <= ~btn[JOY_FIRE];
      in1   <= 8'hFF;
      in1[IN1_START1] <= ~start1;
      in1[IN1_START2] <= ~start2;
    end
`ifdef ARCADE_INPUT_4WAY_EN
  logic [3:0] dir_q2, mask_q, mask, rise;
  always_comb begin
    rise = dir_q & ~dir_q2;
    mask = rise[IN0_UP]    ? 4'b0001 << IN0_UP :
           rise[IN0_DOWN]  ? 4'b0001 << IN0_DOWN :
           rise[IN0_LEFT]  ? 4'b0001 << IN0_LEFT :
           rise[IN0_RIGHT] ? 4'b0001 << IN0_RIGHT : mask_q;
    dir_out = dir_q & mask;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      dir_q2 <= '0;
      mask_q <= '0;
    end else begin
      dir_q2 <= dir_q;
      mask_q <= mask;
    end
`else
  assign dir_out = dir_q;
`endif
  assign in0 = {hi_q, ~dir_out};
  coin_start_seq #(
    .COIN_CYCLES(COIN_CYCLES),
    .GAP_CYCLES(GAP_CYCLES),
    .START_CYCLES(START_CYCLES),
    .CNT_W(CNT_W)
  ) u_seq (
    .clk(CLK),
    .rst(RESET),
    .btn1(btn[JOY_START1]),
    .btn2(btn[JOY_START2]),
    .coin(coin),
    .start1(start1),
    .start2(start2)
  );
endmodule

// File: tb/tb_arcade_input.sv
// tb_arcade_input: scoreboard bench for arcade_input decode, arbiter, rotation and sequencer
module tb_arcade_input;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [15:0] joy0 = '0, joy1 = '0;
  logic rotate = 1'b0;
  logic [7:0] in0, in1;
  int cyc = 0, total = 0, bad = 0;
  typedef struct {
    string tag;
    int due;
    logic [15:0] m;
    logic [15:0] e;
  } exp_t;
  exp_t sb[$];
`ifdef ARCADE_INPUT_4WAY_EN
  localparam bit ARB = 1'b1;
`else
  localparam bit ARB = 1'b0;
`endif
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  arcade_input #(.COIN_CYCLES(4), .GAP_CYCLES(2), .START_CYCLES(3)) dut (
    .CLK(CLK), .RESET(RESET), .ps2_key(ps2_key), .joy0(joy0), .joy1(joy1),
    .rotate(rotate), .in0(in0), .in1(in1)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %h want %h", tag, cyc, got, exp);
    end
  endtask
  task automatic expect_at(input string tag, input int dly, input logic [7:0] m0, input logic [7:0] e0,
                           input logic [7:0] m1, input logic [7:0] e1);
    sb.push_back('{tag: tag, due: cyc + dly, m: {m1, m0}, e: {e1, e0}});
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask
  always @(negedge CLK)
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due == cyc) begin
        check(sb[i].tag, {in1, in0} & sb[i].m, sb[i].e);
        sb.delete(i);
      end
  initial begin
    repeat (4) begin
      @(negedge CLK);
      joy0 = 16'($urandom);
      joy1 = 16'($urandom);
      ps2_key = 11'($urandom);
      rotate = 1'($urandom);
      #1 check("reset", {in1, in0}, 16'hFFFF);
    end
    @(negedge CLK);
    joy0 = 16'h0020; joy1 = '0; ps2_key = '0; rotate = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    for (int k = 1; k <= 8; k++) expect_at("held_start_no_coin", k, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    tick(9); joy0 = '0; tick(2);
    ps2_key = {1'b1, 1'b1, 9'h075};
    expect_at("key_up_early", 2, 8'h01, 8'h01, 8'h00, 8'h00);
    expect_at("key_up", 3, 8'h01, 8'h00, 8'h00, 8'h00);
    tick(4); ps2_key = {1'b0, 1'b0, 9'h175};
    expect_at("key_up_rel_early", 2, 8'h01, 8'h00, 8'h00, 8'h00);
    expect_at("key_up_rel", 3, 8'h01, 8'h01, 8'h00, 8'h00);
    tick(4); ps2_key = {1'b0, 1'b1, 9'h075};
    expect_at("key_same_tog", 3, 8'h01, 8'h01, 8'h00, 8'h00);
    expect_at("key_same_tog2", 5, 8'h01, 8'h01, 8'h00, 8'h00);
    tick(6); ps2_key = {1'b1, 1'b1, 9'h029};
    expect_at("key_fire", 3, 8'h10, 8'h00, 8'h00, 8'h00);
    tick(4); ps2_key = {1'b0, 1'b0, 9'h014};
    expect_at("key_fire_rel", 3, 8'h10, 8'h10, 8'h00, 8'h00);
    tick(4); ps2_key = {1'b1, 1'b1, 9'h01C};
    expect_at("key_unknown", 3, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    tick(4); ps2_key = {1'b0, 1'b0, 9'h01C}; tick(4);
    joy1[6] = 1'b1;
    for (int d = 2; d <= 20; d++)
      expect_at("seq", d, 8'h20, (d >= 3 && d <= 6) ? 8'h00 : 8'h20,
                8'h60, (d >= 9 && d <= 11) ? 8'h20 : 8'h60);
    tick(5); joy0[5] = 1'b1;
    tick(2); joy0[5] = 1'b0;
    tick(8); joy1[6] = 1'b0; tick(8);
    joy0 = 16'h0002;
    expect_at("left", 1, 8'h0F, 8'h0D, 8'h00, 8'h00);
    tick(2); joy1 = 16'h0008;
    expect_at("add_up", 1, 8'h0F, ARB ? 8'h0E : 8'h0C, 8'h00, 8'h00);
    expect_at("add_up_hold", 3, 8'h0F, ARB ? 8'h0E : 8'h0C, 8'h00, 8'h00);
    tick(4); joy1 = '0;
    expect_at("rel_up", 1, 8'h0F, ARB ? 8'h0F : 8'h0D, 8'h00, 8'h00);
    expect_at("rel_up_hold", 3, 8'h0F, ARB ? 8'h0F : 8'h0D, 8'h00, 8'h00);
    tick(4); joy0 = '0; tick(3);
    joy0 = 16'h000C;
    expect_at("up_down", 1, 8'h0F, ARB ? 8'h0E : 8'h06, 8'h00, 8'h00);
    tick(3); joy0 = '0; tick(3);
    rotate = 1'b1; tick(2);
    joy0 = 16'h0002;
    expect_at("rot_left_up", 1, 8'h0F, 8'h0E, 8'h00, 8'h00);
    tick(3); joy0 = 16'h0008;
    expect_at("rot_up_right", 1, 8'h0F, 8'h0B, 8'h00, 8'h00);
    tick(3); joy0 = '0; rotate = 1'b0; tick(3);
    joy0[5] = 1'b1;
    expect_at("coin_mid", 3, 8'h20, 8'h00, 8'h00, 8'h00);
    tick(4);
    RESET = 1'b1;
    #1 check("async_rst", {in1, in0}, 16'hFFFF);
    @(negedge CLK);
    RESET = 1'b0; joy0 = '0;
    for (int k = 1; k <= 12; k++) expect_at("post_rst_idle", k, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) check("sb_drain", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
